core_decode: RTL and testbench
==============================

# core_decode

Instruction decode stage of the RV32I core. Sits between fetch and execute, and drives the read ports of `core_registers`. The register file has a one-cycle registered read, so this block registers the decoded fields alongside it. That way the operand values and the decoded instruction reach execute in the same cycle. It also forwards same-edge write-back data that the register file read would miss, and applies a valid/ready handshake with flush on both sides.

## Interface
Parameters:
- `RESET_PC`, 32'h0000_0000: value of `OPC` while reset or after flush.

Ports:
- `CLK` in 1: core clock; all state updates on rising edge.
- `NRST` in 1: synchronous active-low reset.
- `IVALID` in 1: fetch presents an instruction.
- `IREADY` out 1: decode can accept; `IREADY = ~OVALID | OREADY` (combinational).
- `IDATA` in 32: instruction word.
- `IPC` in 32: instruction address.
- `ARADDR1` out 5: register file read address 1.
- `ARADDR2` out 5: register file read address 2.
- `RDATA1` in 32: register file read data 1, valid one cycle after address.
- `RDATA2` in 32: register file read data 2, valid one cycle after address.
- `WB_VALID` in 1: snoop of the register file write strobe (same net as its `AWVALID`).
- `WB_ADDR` in 5: snoop of the register file write address.
- `WB_DATA` in 32: snoop of the register file write data.
- `FLUSH` in 1: discard held and incoming instruction (branch/jump redirect).
- `OVALID` out 1: decoded instruction valid to execute.
- `OREADY` in 1: execute accepts.
- `OPC` out 32: PC of the decoded instruction.
- `OPA` out 32: rs1 value.
- `OPB` out 32: rs2 value.
- `OIMM` out 32: sign-extended immediate.
- `ORD` out 5: destination register; 0 if the instruction writes none.
- `OOPCODE` out 7: `instr[6:0]`.
- `OFUNCT3` out 3: `instr[14:12]`.
- `OALT` out 1: `instr[30]` (SUB/SRA select).
- `OILLEGAL` out 1: opcode not in the RV32I base set, or `instr[1:0]` != 2'b11.

## Operation
- Accept = `IVALID & IREADY & ~FLUSH`. On accept, register `IDATA`, `IPC` and the decoded fields, and set `OVALID`.
- If `OVALID & OREADY` and no accept, clear `OVALID`.
- Stall (`OVALID & ~OREADY`): hold all registered fields.
- `ARADDR1`/`ARADDR2` are combinational:
  - on an accept cycle, `IDATA[19:15]`/`IDATA[24:20]`;
  - otherwise, the held instruction's rs1/rs2 fields.
  - This makes the register file re-read held operands every stall cycle, so writes that retire during a stall are picked up.
- ARADDR is driven from the raw bit fields for every format. Unused reads are harmless.
- Bypass: each edge, set `hit1 <= WB_VALID & (WB_ADDR != 0) & (WB_ADDR == ARADDR1)` and `byp1 <= WB_DATA`. Same for `hit2`/`byp2`.
  - `OPA = hit1 ? byp1 : RDATA1`; `OPB = hit2 ? byp2 : RDATA2` (combinational).
  - The bypass covers the case where the register file reads the old value on the edge it is written.
- `OPA`/`OPB` may change while stalled (newer write-back). Execute samples them on the `OVALID & OREADY` cycle.
- Immediate by opcode:
  - I-type (JALR, LOAD, OP-IMM, MISC-MEM, SYSTEM): `sext(instr[31:20])`.
  - S (STORE): `sext({instr[31:25], instr[11:7]})`.
  - B (BRANCH): `sext({instr[31], instr[7], instr[30:25], instr[11:8], 1'b0})`.
  - U (LUI, AUIPC): `{instr[31:12], 12'b0}`.
  - J (JAL): `sext({instr[31], instr[19:12], instr[20], instr[30:21], 1'b0})`.
  - OP and illegal: 0.
- `ORD = instr[11:7]` for LUI, AUIPC, JAL, JALR, LOAD, OP-IMM and OP; else 0.
- Illegal instructions still pass through with `OILLEGAL = 1`. `ORD = 0` and `OIMM = 0` for them.

## Timing
- Latency: instruction accepted at edge k → `OVALID` and all fields valid after edge k; `OPA`/`OPB` correct after edge k (the register file read occurs at edge k).
- Throughput: 1 instruction/cycle when `OREADY` is held high.
- `FLUSH` has priority over accept and hold. At the next edge: `OVALID = 0`, `OPC = RESET_PC`, other fields 0, `hit1`/`hit2` = 0. The instruction offered that cycle is dropped; `IREADY` is not gated by `FLUSH`.
- Simultaneous drain and accept (`OVALID & OREADY & IVALID`): new instruction replaces old, and `OVALID` stays 1.
- A write-back to x0 is never bypassed. A write-back on the same edge as a register file read of the same register is bypassed. A write-back one or more cycles earlier is already in the register file, so no bypass is needed.
- Reset, at the next edge while `NRST = 0`:
  - `OVALID = 0`, `OPC = RESET_PC`;
  - `OIMM`, `ORD`, `OOPCODE`, `OFUNCT3`, `OALT`, `OILLEGAL`, `hit1`, `hit2`, `byp1`, `byp2` = 0;
  - `OPA`/`OPB` read 0 because the register file's reset also clears its `RDATA1`/`RDATA2`.
- Reset mid-stall discards the held instruction.

## Test plan
- `addi x5,x0,-3` (32'hFFD00293) with `OREADY = 1` → next cycle `OVALID = 1`, `OIMM` = 32'hFFFF_FFFD, `ORD` = 5, `OOPCODE` = 7'h13, `OILLEGAL` = 0.
- Write-back x3 = 32'h1234_5678 on the same edge that `add x1,x3,x3` is accepted → `OPA` = `OPB` = 32'h1234_5678 (bypass); the same write-back to x0 → `OPA` = 0.
- Hold `OREADY = 0` for 3 cycles with `beq x2,x4,-8` held; write x2 = 7 during cycle 2 → `OVALID`, `OPC` and `OIMM` (= 32'hFFFF_FFF8) stable, `IREADY = 0`, and `OPA` becomes 7 within 1 cycle.
- Back-to-back LUI / JAL / SW with `OREADY = 1` → one output per cycle with U/J/S immediates correct; `ORD` = 0 for SW.
- Assert `FLUSH` with `OVALID = 1` and `IVALID = 1` → next cycle `OVALID = 0`, `OPC = RESET_PC`, and the offered instruction is not emitted.
- IDATA = 32'h0000_0000 → `OILLEGAL = 1`, `ORD = 0`, `OIMM = 0`. Then assert `NRST = 0` mid-stall → all outputs at reset values after one edge.

Source files
------------

// File: rtl/core_decode.sv
// RV32I decode stage: registers decoded fields in step with the register file's
// one-cycle read and bypasses same-edge write-backs into the operands.
module core_decode #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        CLK,
  input  logic        NRST,
  input  logic        IVALID,
  output logic        IREADY,
  input  logic [31:0] IDATA,
  input  logic [31:0] IPC,
  output logic [4:0]  ARADDR1,
  output logic [4:0]  ARADDR2,
  input  logic [31:0] RDATA1,
  input  logic [31:0] RDATA2,
  input  logic        WB_VALID,
  input  logic [4:0]  WB_ADDR,
  input  logic [31:0] WB_DATA,
  input  logic        FLUSH,
  output logic        OVALID,
  input  logic        OREADY,
  output logic [31:0] OPC,
  output logic [31:0] OPA,
  output logic [31:0] OPB,
  output logic [31:0] OIMM,
  output logic [4:0]  ORD,
  output logic [6:0]  OOPCODE,
  output logic [2:0]  OFUNCT3,
  output logic        OALT,
  output logic        OILLEGAL
);

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_OPIMM  = 7'b0010011;
  localparam logic [6:0] OP_OP     = 7'b0110011;
  localparam logic [6:0] OP_MISC   = 7'b0001111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  logic        r_valid;
  logic [31:0] r_pc;
  logic [31:0] r_imm;
  logic [4:0]  r_rd;
  logic [4:0]  r_rs1;
  logic [4:0]  r_rs2;
  logic [6:0]  r_opcode;
  logic [2:0]  r_funct3;
  logic        r_alt;
  logic        r_illegal;
  logic        r_hit1;
  logic        r_hit2;
  logic [31:0] r_byp1;
  logic [31:0] r_byp2;

  logic        w_accept;
  logic [31:0] w_imm;
  logic [4:0]  w_rd;
  logic        w_illegal;
  logic [31:0] w_i_imm;

  assign IREADY   = ~r_valid | OREADY;
  assign w_accept = IVALID & IREADY & ~FLUSH;

  // Re-address the held instruction while stalled so retiring writes are re-read.
  assign ARADDR1 = w_accept ? IDATA[19:15] : r_rs1;
  assign ARADDR2 = w_accept ? IDATA[24:20] : r_rs2;

  assign w_i_imm = {{20{IDATA[31]}}, IDATA[31:20]};

  always_comb begin
    w_imm     = 32'h0;
    w_rd      = 5'd0;
    w_illegal = 1'b0;
    case (IDATA[6:0])
      OP_LUI, OP_AUIPC: begin
        w_imm = {IDATA[31:12], 12'h000};
        w_rd  = IDATA[11:7];
      end
      OP_JAL: begin
        w_imm = {{12{IDATA[31]}}, IDATA[19:12], IDATA[20], IDATA[30:21], 1'b0};
        w_rd  = IDATA[11:7];
      end
      OP_JALR, OP_LOAD, OP_OPIMM: begin
        w_imm = w_i_imm;
        w_rd  = IDATA[11:7];
      end
      OP_MISC, OP_SYSTEM: w_imm = w_i_imm;
      OP_STORE:  w_imm = {{21{IDATA[31]}}, IDATA[30:25], IDATA[11:7]};
      OP_BRANCH: w_imm = {{20{IDATA[31]}}, IDATA[7], IDATA[30:25], IDATA[11:8], 1'b0};
      OP_OP:     w_rd  = IDATA[11:7];
      default:   w_illegal = 1'b1;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!NRST || FLUSH) begin
      r_valid   <= 1'b0;
      r_pc      <= RESET_PC;
      r_imm     <= 32'h0;
      r_rd      <= 5'd0;
      r_rs1     <= 5'd0;
      r_rs2     <= 5'd0;
      r_opcode  <= 7'd0;
      r_funct3  <= 3'd0;
      r_alt     <= 1'b0;
      r_illegal <= 1'b0;
      r_hit1    <= 1'b0;
      r_hit2    <= 1'b0;
      r_byp1    <= 32'h0;
      r_byp2    <= 32'h0;
    end else begin
      if (w_accept) begin
        r_valid   <= 1'b1;
        r_pc      <= IPC;
        r_imm     <= w_imm;
        r_rd      <= w_rd;
        r_rs1     <= IDATA[19:15];
        r_rs2     <= IDATA[24:20];
        r_opcode  <= IDATA[6:0];
        r_funct3  <= IDATA[14:12];
        r_alt     <= IDATA[30];
        r_illegal <= w_illegal;
      end else if (r_valid && OREADY) begin
        r_valid <= 1'b0;
      end
      // Register file returns the pre-write value on a same-edge write; catch it here.
      r_hit1 <= WB_VALID & (WB_ADDR != 5'd0) & (WB_ADDR == ARADDR1);
      r_hit2 <= WB_VALID & (WB_ADDR != 5'd0) & (WB_ADDR == ARADDR2);
      r_byp1 <= WB_DATA;
      r_byp2 <= WB_DATA;
    end
  end

  assign OVALID   = r_valid;
  assign OPC      = r_pc;
  assign OPA      = r_hit1 ? r_byp1 : RDATA1;
  assign OPB      = r_hit2 ? r_byp2 : RDATA2;
  assign OIMM     = r_imm;
  assign ORD      = r_rd;
  assign OOPCODE  = r_opcode;
  assign OFUNCT3  = r_funct3;
  assign OALT     = r_alt;
  assign OILLEGAL = r_illegal;

endmodule

// File: tb/tb_core_decode.sv
// Bench for core_decode: register-file model, behavioural decode reference, directed + random stimulus.
module tb_core_decode;
  logic        CLK, NRST, IVALID, IREADY, WB_VALID, FLUSH, OVALID, OREADY, OALT, OILLEGAL;
  logic [31:0] IDATA, IPC, RDATA1, RDATA2, WB_DATA, OPC, OPA, OPB, OIMM;
  logic [4:0]  ARADDR1, ARADDR2, WB_ADDR, ORD;
  logic [6:0]  OOPCODE;
  logic [2:0]  OFUNCT3;

  core_decode #(.RESET_PC(32'h0000_0000)) dut (
    .CLK(CLK), .NRST(NRST), .IVALID(IVALID), .IREADY(IREADY), .IDATA(IDATA), .IPC(IPC),
    .ARADDR1(ARADDR1), .ARADDR2(ARADDR2), .RDATA1(RDATA1), .RDATA2(RDATA2),
    .WB_VALID(WB_VALID), .WB_ADDR(WB_ADDR), .WB_DATA(WB_DATA), .FLUSH(FLUSH),
    .OVALID(OVALID), .OREADY(OREADY), .OPC(OPC), .OPA(OPA), .OPB(OPB), .OIMM(OIMM),
    .ORD(ORD), .OOPCODE(OOPCODE), .OFUNCT3(OFUNCT3), .OALT(OALT), .OILLEGAL(OILLEGAL)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h at %0t", nm, act, exp, $time);
  endtask

  // Register file: one-cycle registered read returning pre-write data, RDATA cleared by reset.
  logic [31:0] regs [32];
  always @(posedge CLK) begin
    if (!NRST) begin
      RDATA1 <= 32'h0;
      RDATA2 <= 32'h0;
      for (int i = 0; i < 32; i++) regs[i] <= (i == 0) ? 32'h0 : 32'hA000_0000 + 32'(i * 32'h0101);
    end else begin
      RDATA1 <= regs[ARADDR1];
      RDATA2 <= regs[ARADDR2];
      if (WB_VALID && WB_ADDR != 5'd0) regs[WB_ADDR] <= WB_DATA;
    end
  end

  // Reference decode, computed from the ISA immediate definitions as plain integers.
  function automatic logic [31:0] m_imm(input logic [31:0] x);
    int v;
    int s;
    s = x[31] ? 1 : 0;
    case (x[6:0])
      7'h67, 7'h03, 7'h13, 7'h0F, 7'h73: v = -s * 2048 + int'(x[30:20]);
      7'h23: v = -s * 2048 + int'(x[30:25]) * 32 + int'(x[11:7]);
      7'h63: v = -s * 4096 + int'(x[7]) * 2048 + int'(x[30:25]) * 32 + int'(x[11:8]) * 2;
      7'h37, 7'h17: v = int'(x[31:12]) * 4096;
      7'h6F: v = -s * 1048576 + int'(x[19:12]) * 4096 + int'(x[20]) * 2048 + int'(x[30:21]) * 2;
      default: v = 0;
    endcase
    return 32'(v);
  endfunction

  function automatic logic m_legal(input logic [31:0] x);
    return x[6:0] inside {7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03, 7'h23, 7'h13, 7'h33, 7'h0F, 7'h73};
  endfunction

  function automatic logic [4:0] m_rd(input logic [31:0] x);
    return (x[6:0] inside {7'h37, 7'h17, 7'h6F, 7'h67, 7'h03, 7'h13, 7'h33}) ? x[11:7] : 5'd0;
  endfunction

  // Model of the stage contents: which instruction is held, and whether it is valid or cleared.
  logic        exp_valid, exp_clr;
  logic [31:0] exp_instr, exp_pc;
  wire         m_acc = IVALID && (!exp_valid || OREADY) && !FLUSH;

  always @(posedge CLK) begin
    if (!NRST || FLUSH) begin
      exp_valid <= 1'b0;
      exp_clr   <= 1'b1;
      exp_pc    <= 32'h0;
      exp_instr <= 32'h0;
    end else if (m_acc) begin
      exp_valid <= 1'b1;
      exp_clr   <= 1'b0;
      exp_pc    <= IPC;
      exp_instr <= IDATA;
    end else if (exp_valid && OREADY) begin
      exp_valid <= 1'b0;
    end
  end

  logic checking = 1'b0;
  always @(negedge CLK) begin
    if (checking) begin
      chk("IREADY", 32'(IREADY), 32'(!exp_valid || OREADY));
      chk("ARADDR1", 32'(ARADDR1), 32'(m_acc ? IDATA[19:15] : exp_instr[19:15]));
      chk("ARADDR2", 32'(ARADDR2), 32'(m_acc ? IDATA[24:20] : exp_instr[24:20]));
      chk("OVALID", 32'(OVALID), 32'(exp_valid));
      chk("OPC", OPC, exp_pc);
      chk("OIMM", OIMM, (exp_clr || !m_legal(exp_instr)) ? 32'h0 : m_imm(exp_instr));
      chk("ORD", 32'(ORD), (exp_clr || !m_legal(exp_instr)) ? 32'h0 : 32'(m_rd(exp_instr)));
      chk("OOPCODE", 32'(OOPCODE), exp_clr ? 32'h0 : 32'(exp_instr[6:0]));
      chk("OFUNCT3", 32'(OFUNCT3), exp_clr ? 32'h0 : 32'(exp_instr[14:12]));
      chk("OALT", 32'(OALT), exp_clr ? 32'h0 : 32'(exp_instr[30]));
      chk("OILLEGAL", 32'(OILLEGAL), exp_clr ? 32'h0 : 32'(!m_legal(exp_instr)));
      if (exp_valid) begin
        chk("OPA", OPA, regs[exp_instr[19:15]]);
        chk("OPB", OPB, regs[exp_instr[24:20]]);
      end
    end
  end

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle();
    IVALID = 1'b0; WB_VALID = 1'b0; FLUSH = 1'b0;
  endtask

  task automatic offer(input logic [31:0] ins, input logic [31:0] pc);
    IVALID = 1'b1; IDATA = ins; IPC = pc;
  endtask

  logic [31:0] rnd, ins;
  logic [6:0]  ops [13];

  initial begin
    NRST = 1'b0; OREADY = 1'b1; IDATA = 32'h0; IPC = 32'h0; WB_ADDR = 5'd0; WB_DATA = 32'h0;
    idle();
    step(); step();
    checking = 1'b1;
    chk("rst OVALID", 32'(OVALID), 32'h0);
    chk("rst OPC", OPC, 32'h0);
    chk("rst OPA", OPA, 32'h0);
    NRST = 1'b1;

    // addi x5,x0,-3
    offer(32'hFFD00293, 32'h100); step(); idle();
    chk("addi OVALID", 32'(OVALID), 32'h1);
    chk("addi OIMM", OIMM, 32'hFFFF_FFFD);
    chk("addi ORD", 32'(ORD), 32'd5);
    chk("addi OOPCODE", 32'(OOPCODE), 32'h13);
    chk("addi OILLEGAL", 32'(OILLEGAL), 32'h0);

    // add x1,x3,x3 accepted on the same edge x3 is written
    offer(32'h003180B3, 32'h104); WB_VALID = 1'b1; WB_ADDR = 5'd3; WB_DATA = 32'h1234_5678;
    step(); idle();
    chk("byp OPA", OPA, 32'h1234_5678);
    chk("byp OPB", OPB, 32'h1234_5678);
    // add x1,x0,x0 with a write-back aimed at x0
    offer(32'h000000B3, 32'h108); WB_VALID = 1'b1; WB_ADDR = 5'd0; WB_DATA = 32'h1234_5678;
    step(); idle();
    chk("x0 OPA", OPA, 32'h0);
    step();

    // beq x2,x4,-8 held by a stall; x2 written on the second stall edge
    OREADY = 1'b0;
    offer(32'hFE410CE3, 32'h200); step(); idle();
    step();
    WB_VALID = 1'b1; WB_ADDR = 5'd2; WB_DATA = 32'd7;
    step(); idle();
    chk("stall OPA", OPA, 32'd7);
    chk("stall OIMM", OIMM, 32'hFFFF_FFF8);
    chk("stall OPC", OPC, 32'h200);
    chk("stall IREADY", 32'(IREADY), 32'h0);
    chk("stall OVALID", 32'(OVALID), 32'h1);
    step();
    chk("stall OPA late", OPA, 32'd7);
    OREADY = 1'b1; step();

    // lui x7,0x12345 / jal x1,+0x800 / sw x5,-4(x2) back to back
    offer(32'h123453B7, 32'h300); step();
    chk("lui OIMM", OIMM, 32'h1234_5000);
    chk("lui ORD", 32'(ORD), 32'd7);
    offer(32'h001000EF, 32'h304); step();
    chk("jal OIMM", OIMM, 32'h0000_0800);
    chk("jal OPC", OPC, 32'h304);
    offer(32'hFE512E23, 32'h308); step(); idle();
    chk("sw OIMM", OIMM, 32'hFFFF_FFFC);
    chk("sw ORD", 32'(ORD), 32'd0);
    chk("sw OVALID", 32'(OVALID), 32'h1);
    step();

    // flush while holding and while a new instruction is offered
    OREADY = 1'b0;
    offer(32'hFFD00293, 32'h400); step();
    offer(32'h123453B7, 32'h404); FLUSH = 1'b1; step(); idle();
    chk("flush OVALID", 32'(OVALID), 32'h0);
    chk("flush OPC", OPC, 32'h0);
    step();
    chk("flush dropped", 32'(OVALID), 32'h0);

    // all-zero word is illegal; then reset while it is stalled
    offer(32'h0000_0000, 32'h500); step(); idle();
    chk("ill OILLEGAL", 32'(OILLEGAL), 32'h1);
    chk("ill ORD", 32'(ORD), 32'h0);
    chk("ill OIMM", OIMM, 32'h0);
    step();
    NRST = 1'b0; step(); NRST = 1'b1;
    chk("rst2 OVALID", 32'(OVALID), 32'h0);
    chk("rst2 OILLEGAL", 32'(OILLEGAL), 32'h0);
    chk("rst2 OPA", OPA, 32'h0);
    OREADY = 1'b1;

    ops = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03, 7'h23, 7'h13, 7'h33, 7'h0F, 7'h73, 7'h00, 7'h7F};
    for (int c = 0; c < 4000; c++) begin
      rnd = $urandom;
      ins = {rnd[31:25], 5'(rnd[22:20] & 3'h7), 5'($urandom_range(0, 7)), rnd[14:7], ops[$urandom_range(0, 12)]};
      if ($urandom_range(0, 19) == 0) ins = $urandom;
      IVALID   = ($urandom_range(0, 9) < 7);
      IDATA    = ins;
      IPC      = $urandom;
      OREADY   = ($urandom_range(0, 9) < 7);
      FLUSH    = ($urandom_range(0, 29) == 0);
      NRST     = ($urandom_range(0, 199) != 0);
      WB_VALID = NRST && ($urandom_range(0, 1) == 1);
      WB_ADDR  = 5'($urandom_range(0, 7));
      WB_DATA  = $urandom;
      step();
    end
    NRST = 1'b1; idle(); OREADY = 1'b1;
    step(); step();
    checking = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
